// File: rtl/signed_comparator.sv
// Registered three-way signed comparator: dout is +1 (A>B), 0 (A==B) or -2 (A<B),
// one cycle after the operands are sampled.
module signed_comparator #(
  parameter int WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [2:0]       dout
);

  // The less-than code is -2 rather than -1 so that downstream arithmetic can
  // tell it apart from the greater-than code by magnitude as well as by sign.
  typedef enum logic [2:0] {
    CMP_EQ = 3'b000,
    CMP_GT = 3'b001,
    CMP_LT = 3'b110
  } cmp_code_e;

  cmp_code_e dout_d;
  cmp_code_e dout_q;

  always_comb begin
    dout_d = CMP_EQ;
    if (A > B) begin
      dout_d = CMP_GT;
    end else if (A < B) begin
      dout_d = CMP_LT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q <= CMP_EQ;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_signed_comparator.sv
// Self-checking bench for signed_comparator: directed corner cases plus random
// operands checked against an integer-arithmetic reference.
module tb_signed_comparator;

  localparam int W = 16;

  logic                CLK;
  logic                RST;
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic signed [2:0]   dout;

  int n_vec = 0;
  int n_err = 0;

  signed_comparator #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .A    (A),
    .B    (B),
    .dout (dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Operand value as a plain integer, from the two's-complement rule.
  function automatic int to_int(input logic [W-1:0] v);
    int r;
    r = int'(v);
    if (v[W-1]) r = r - (1 << W);
    return r;
  endfunction

  function automatic logic [2:0] ref_code(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia;
    int ib;
    int res;
    ia = to_int(a);
    ib = to_int(b);
    if (ia > ib)       res = 1;
    else if (ia == ib) res = 0;
    else               res = -2;
    return 3'(res);
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: dout=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    @(posedge CLK);
    #1;
    check(tag, dout, ref_code(a, b));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset with unequal operands must still give the equal code.
    RST = 1'b1;
    A   = 16'sd5;
    B   = -16'sd2;
    repeat (2) @(posedge CLK);
    #1;
    check("reset", dout, 3'b000);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("first_after_reset", dout, 3'b001);

    apply("gt_5_4",      16'sd5,  16'sd4);
    apply("gt_5_m2",     16'sd5,  -16'sd2);
    apply("gt_m4_m8",    -16'sd4, -16'sd8);
    apply("eq_4_4",      16'sd4,  16'sd4);
    apply("eq_m2_m2",    -16'sd2, -16'sd2);
    apply("eq_0_0",      16'sd0,  16'sd0);
    apply("lt_4_5",      16'sd4,  16'sd5);
    apply("lt_m2_5",     -16'sd2, 16'sd5);
    apply("lt_m8_m4",    -16'sd8, -16'sd4);
    apply("min_lt_max",  16'h8000, 16'h7FFF);
    apply("max_gt_min",  16'h7FFF, 16'h8000);
    apply("min_eq_min",  16'h8000, 16'h8000);
    apply("max_eq_max",  16'h7FFF, 16'h7FFF);
    apply("min_lt_m1",   16'h8000, 16'hFFFF);
    apply("m1_lt_0",     16'hFFFF, 16'h0000);

    // Back-to-back >, <, = with no idle cycles.
    apply("seq_gt", 16'sd5, 16'sd4);
    apply("seq_lt", 16'sd4, 16'sd5);
    apply("seq_eq", 16'sd4, 16'sd4);

    // Mid-cycle operand change must not reach dout before the next edge.
    apply("hold_pre", 16'sd5, 16'sd4);
    #2;
    A = 16'sd1;
    B = 16'sd9;
    @(negedge CLK);
    check("hold_mid", dout, 3'b001);
    @(posedge CLK);
    #1;
    check("hold_post", dout, 3'b110);

    // RST raised between edges acts only at the edge, then releases cleanly.
    apply("rst_setup", 16'sd5, 16'sd4);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_between_edges", dout, 3'b001);
    @(posedge CLK);
    #1;
    check("rst_edge", dout, 3'b000);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_release", dout, 3'b001);

    // Random operands, biased to hit equality and sign boundaries often.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ {1'b1, {(W-1){1'b0}}};
        2:       rb = ra + W'($urandom_range(0, 2)) - W'(1);
        default: rb = W'($urandom);
      endcase
      apply("random", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
